// File: rtl/fixedpoint_addsub_pipe.sv
// Fixed-point add/subtract with operand alignment, optional round-half-up and saturation.
// Latency 2 cycles at 1 beat/cycle; valid/ready backpressure stalls both stages and S2 holds its beat.
module fixedpoint_addsub_pipe #(
    parameter int WI1 = 3,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 3,
    parameter int WIO = ((WI1 > WI2) ? WI1 : WI2) + 1,
    parameter int WFO = (WF1 > WF2) ? WF1 : WF2,
    parameter bit SAT = 1'b0,
    parameter bit RND = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op,
    input  logic [WI1+WF1-1:0] in1,
    input  logic [WI2+WF2-1:0] in2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIO+WFO-1:0] out_data,
    output logic               overflow,
    output logic               ovf_sticky,
    input  logic               ovf_clr
);

    localparam int WI = (WI1 > WI2) ? WI1 : WI2;
    localparam int WF = (WF1 > WF2) ? WF1 : WF2;
    localparam int W1 = WI1 + WF1;
    localparam int W2 = WI2 + WF2;
    localparam int WA = WI + WF;
    localparam int WS = WA + 1;
    localparam int WO = WIO + WFO;
    // Width of the rescaled value; the narrowing path keeps one guard bit for the rounding add.
    localparam int WR = (WFO >= WF) ? (WS + WFO - WF) : (WS + 1 - (WF - WFO));

    logic signed [W1-1:0] in1_s;
    logic signed [W2-1:0] in2_s;
    logic signed [WA-1:0] a_al;
    logic signed [WA-1:0] b_al;

    logic                 s1_vld_q, s1_vld_d;
    logic signed [WA-1:0] s1_a_q, s1_a_d;
    logic signed [WA-1:0] s1_b_q, s1_b_d;
    logic                 s1_op_q, s1_op_d;

    logic                 s2_vld_q, s2_vld_d;
    logic [WO-1:0]        s2_dat_q, s2_dat_d;
    logic                 s2_ovf_q, s2_ovf_d;
    logic                 sticky_q, sticky_d;

    logic                 s1_adv;
    logic                 s2_adv;
    logic                 s2_load;

    logic signed [WS-1:0] sum_ex;
    logic signed [WR-1:0] rnd_v;
    logic [WO-1:0]        wrap_v;
    logic                 ovf_n;
    logic [WO-1:0]        sat_pos;
    logic [WO-1:0]        sat_neg;

    assign in1_s = in1;
    assign in2_s = in2;
    assign a_al  = WA'(in1_s) <<< (WF - WF1);
    assign b_al  = WA'(in2_s) <<< (WF - WF2);

    assign s2_adv   = !s2_vld_q || out_ready;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign s2_load  = s2_adv && s1_vld_q;
    assign in_ready = s1_adv;

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_op_d  = s1_op_q;
        if (s1_adv) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_a_d  = a_al;
                s1_b_d  = b_al;
                s1_op_d = op;
            end
        end
    end

    // One extra bit makes both the sum and the negation of the most-negative operand exact.
    always_comb begin
        sum_ex = s1_op_q ? (WS'(s1_a_q) - WS'(s1_b_q)) : (WS'(s1_a_q) + WS'(s1_b_q));
    end

    if (WFO >= WF) begin : g_pad
        assign rnd_v = WR'(sum_ex) <<< (WFO - WF);
    end else begin : g_cut
        localparam int SH = WF - WFO;
        localparam int WG = WS + 1;
        logic signed [WG-1:0] sum_g;
        logic signed [WG-1:0] half;
        always_comb begin
            half         = '0;
            half[SH-1]   = RND;
        end
        assign sum_g = WG'(sum_ex);
        assign rnd_v = WR'((sum_g + half) >>> SH);
    end

    if (WR > WO) begin : g_rng
        logic [WR-WO:0] hi;
        assign hi     = rnd_v[WR-1:WO-1];
        assign wrap_v = rnd_v[WO-1:0];
        assign ovf_n  = !((&hi) || !(|hi));
    end else begin : g_fit
        assign wrap_v = WO'(rnd_v);
        assign ovf_n  = 1'b0;
    end

    always_comb begin
        sat_pos         = '1;
        sat_pos[WO-1]   = 1'b0;
        sat_neg         = '0;
        sat_neg[WO-1]   = 1'b1;
    end

    always_comb begin
        s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
        s2_dat_d = s2_dat_q;
        s2_ovf_d = s2_ovf_q;
        if (s2_load) begin
            s2_ovf_d = ovf_n;
            s2_dat_d = (SAT && ovf_n) ? (rnd_v[WR-1] ? sat_neg : sat_pos) : wrap_v;
        end
        // A new overflow beat beats a simultaneous clear.
        sticky_d = sticky_q;
        if (ovf_clr) begin
            sticky_d = 1'b0;
        end
        if (s2_load && ovf_n) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
            s2_ovf_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_op_q  <= s1_op_d;
            s2_vld_q <= s2_vld_d;
            s2_dat_q <= s2_dat_d;
            s2_ovf_q <= s2_ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign out_data   = s2_dat_q;
    assign overflow   = s2_ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fixedpoint_addsub_pipe.sv
// Scoreboard bench for fixedpoint_addsub_pipe: five parameterisations share one stimulus stream.
module tb_fixedpoint_addsub_pipe;

    typedef struct packed {
        logic [6:0] in1;
        logic [6:0] in2;
        logic       op;
        logic [8:0] e0;
        logic [6:0] e1;
        logic [6:0] e2;
        logic [6:0] e3;
        logic [6:0] e4;
        logic       ov;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       op = 1'b0;
    logic       out_ready = 1'b1;
    logic       ovf_clr = 1'b0;
    logic [6:0] in1 = '0;
    logic [6:0] in2 = '0;

    logic [4:0] rdy, vld, ovf, stk;
    logic [8:0] d0_dat;
    logic [6:0] dat [1:4];

    vec_t tab [10];
    vec_t sb_q [$];
    vec_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_waits = 0;

    always #5 clk = ~clk;

    fixedpoint_addsub_pipe u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .op(op),
        .in1(in1), .in2(in2), .out_valid(vld[0]), .out_ready(out_ready),
        .out_data(d0_dat), .overflow(ovf[0]), .ovf_sticky(stk[0]), .ovf_clr(ovf_clr));

    fixedpoint_addsub_pipe #(.WIO(3), .WFO(4), .SAT(1'b0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .op(op),
        .in1(in1), .in2(in2), .out_valid(vld[1]), .out_ready(out_ready),
        .out_data(dat[1]), .overflow(ovf[1]), .ovf_sticky(stk[1]), .ovf_clr(ovf_clr));

    fixedpoint_addsub_pipe #(.WIO(3), .WFO(4), .SAT(1'b1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .op(op),
        .in1(in1), .in2(in2), .out_valid(vld[2]), .out_ready(out_ready),
        .out_data(dat[2]), .overflow(ovf[2]), .ovf_sticky(stk[2]), .ovf_clr(ovf_clr));

    fixedpoint_addsub_pipe #(.WFO(2), .RND(1'b0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .op(op),
        .in1(in1), .in2(in2), .out_valid(vld[3]), .out_ready(out_ready),
        .out_data(dat[3]), .overflow(ovf[3]), .ovf_sticky(stk[3]), .ovf_clr(ovf_clr));

    fixedpoint_addsub_pipe #(.WFO(2), .RND(1'b1)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[4]), .op(op),
        .in1(in1), .in2(in2), .out_valid(vld[4]), .out_ready(out_ready),
        .out_data(dat[4]), .overflow(ovf[4]), .ovf_sticky(stk[4]), .ovf_clr(ovf_clr));

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && vld[0] && out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no beat at %0t", d0_dat, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("d0_data", 16'(d0_dat), 16'(mon_e.e0));
                chk("d1_wrap_data", 16'(dat[1]), 16'(mon_e.e1));
                chk("d2_sat_data", 16'(dat[2]), 16'(mon_e.e2));
                chk("d3_trunc_data", 16'(dat[3]), 16'(mon_e.e3));
                chk("d4_round_data", 16'(dat[4]), 16'(mon_e.e4));
                chk("d0_overflow", 16'(ovf[0]), 16'd0);
                chk("d1_overflow", 16'(ovf[1]), 16'(mon_e.ov));
                chk("d2_overflow", 16'(ovf[2]), 16'(mon_e.ov));
                chk("cfg_valid_align", 16'(vld[4:1]), 16'hF);
            end
        end
    end

    task automatic send(input int idx);
        in1      = tab[idx].in1;
        in2      = tab[idx].in2;
        op       = tab[idx].op;
        in_valid = 1'b1;
        last_waits = 0;
        @(negedge clk);
        while (!rdy[0] && last_waits < 50) begin
            last_waits++;
            @(negedge clk);
        end
        if (!rdy[0]) begin
            chk("send_timeout", 16'(rdy[0]), 16'd1);
        end else begin
            sb_q.push_back(tab[idx]);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) begin
            @(negedge clk);
        end
        chk("drain_pending", 16'(sb_q.size()), 16'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d beats pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        //               in1    in2    op    e0      e1     e2     e3     e4     ov
        tab[0] = '{7'h18, 7'h12, 1'b0, 9'h03C, 7'h3C, 7'h3C, 7'h0F, 7'h0F, 1'b0};
        tab[1] = '{7'h18, 7'h12, 1'b1, 9'h1F4, 7'h74, 7'h74, 7'h7D, 7'h7D, 1'b0};
        tab[2] = '{7'h3F, 7'h38, 1'b0, 9'h0AF, 7'h2F, 7'h3F, 7'h2B, 7'h2C, 1'b1};
        tab[3] = '{7'h02, 7'h00, 1'b0, 9'h002, 7'h02, 7'h02, 7'h00, 7'h01, 1'b0};
        tab[4] = '{7'h40, 7'h40, 1'b1, 9'h040, 7'h40, 7'h3F, 7'h10, 7'h10, 1'b1};
        tab[5] = '{7'h40, 7'h01, 1'b1, 9'h1BE, 7'h3E, 7'h40, 7'h6F, 7'h70, 1'b1};
        tab[6] = '{7'h7F, 7'h7F, 1'b0, 9'h1FD, 7'h7D, 7'h7D, 7'h7F, 7'h7F, 1'b0};
        tab[7] = '{7'h01, 7'h01, 1'b0, 9'h003, 7'h03, 7'h03, 7'h00, 7'h01, 1'b0};
        tab[8] = '{7'h3C, 7'h7C, 1'b1, 9'h044, 7'h44, 7'h3F, 7'h11, 7'h11, 1'b1};
        tab[9] = '{7'h7E, 7'h00, 1'b0, 9'h1FE, 7'h7E, 7'h7E, 7'h7F, 7'h00, 1'b0};

        #3;
        chk("rst_out_valid", 16'(vld[0]), 16'd0);
        chk("rst_in_ready", 16'(rdy[0]), 16'd1);
        chk("rst_out_data", 16'(d0_dat), 16'd0);
        chk("rst_overflow", 16'(ovf[0]), 16'd0);
        chk("rst_sticky", 16'(stk[1]), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(0);
        chk("accept_after_reset_waits", 16'(last_waits), 16'd0);
        chk("latency_one_edge", 16'(vld[0]), 16'd0);
        @(posedge clk);
        #1;
        chk("latency_two_edges", 16'(vld[0]), 16'd1);

        for (int i = 1; i < 10; i++) send(i);
        drain();
        chk("sticky_set", 16'(stk[1]), 16'd1);
        chk("sticky_set_sat", 16'(stk[2]), 16'd1);
        chk("sticky_wide_cfg", 16'(stk[0]), 16'd0);

        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("sticky_clear", 16'(stk[1]), 16'd0);

        send(2);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("sticky_set_wins", 16'(stk[1]), 16'd1);
        drain();

        out_ready = 1'b0;
        send(3);
        send(4);
        in1      = tab[5].in1;
        in2      = tab[5].in2;
        op       = tab[5].op;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 16'(rdy[0]), 16'd0);
            chk("bp_hold_data", 16'(d0_dat), 16'(tab[3].e0));
            chk("bp_hold_valid", 16'(vld[0]), 16'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 16'(rdy[0]), 16'd1);
        sb_q.push_back(tab[5]);
        chk("drain_b2b_0", 16'(vld[0]), 16'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("drain_b2b_1", 16'(vld[0]), 16'd1);
        @(negedge clk);
        chk("drain_b2b_2", 16'(vld[0]), 16'd1);
        @(negedge clk);
        chk("drain_empty", 16'(vld[0]), 16'd0);
        drain();

        out_ready = 1'b0;
        send(6);
        send(7);
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", 16'(vld[0]), 16'd0);
        chk("rstmid_in_ready", 16'(rdy[0]), 16'd1);
        chk("rstmid_sticky", 16'(stk[1]), 16'd0);
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(8);
        drain();
        repeat (4) @(negedge clk);
        chk("no_stale_valid", 16'(vld[0]), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
